// File: rtl/img_pkg.sv
// ============================================================================
//  img_pkg : shared types, codes and helpers for the windowed-operator pipeline
//  Revision: 1.0
// ============================================================================
`default_nettype none

package img_pkg;

    // Ceiling log2, never less than 1 so that counters always have a bit.
    function automatic int CLOG2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    localparam int MODE_FILL = 0;
    localparam int MODE_CROP = 1;

    localparam logic [1:0] GAUSSIAN_OP = 2'd0;
    localparam logic [1:0] SOBEL_OP    = 2'd1;

    typedef enum logic [0:0] {
        STREAM = 1'b0,
        DRAIN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/raster_counter.sv
// ============================================================================
//  raster_counter : raster-order (x, y) position tracker, wraps after last pixel
//  Revision: 1.0
// ============================================================================
`default_nettype none

module raster_counter
    import img_pkg::*;
#(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540,
    localparam int XW    = CLOG2(WIDTH),
    localparam int YW    = CLOG2(HEIGHT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          advance,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last_in_row,
    output logic          last_in_frame
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        last_in_row   = (x_q == XW'(WIDTH - 1));
        last_in_frame = last_in_row && (y_q == YW'(HEIGHT - 1));
        x_d = x_q;
        y_d = y_q;
        if (advance) begin
            if (last_in_row) begin
                x_d = '0;
                y_d = last_in_frame ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x = x_q;
    assign y = y_q;

endmodule

`default_nettype wire

// File: rtl/op_depadder.sv
// ============================================================================
//  op_depadder : fills or crops the invalid frame border of a pixel stream
//  Revision: 1.0
// ============================================================================
`default_nettype none

module op_depadder
    import img_pkg::*;
#(
    parameter int                DWIDTH     = 8,
    parameter int                IMG_WIDTH  = 720,
    parameter int                IMG_HEIGHT = 540,
    parameter int                BORDER     = 1,
    parameter int                MODE       = MODE_FILL,
    parameter logic [DWIDTH-1:0] FILL_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    output logic              fifo_in_rd_en,
    input  logic [DWIDTH-1:0] fifo_in_dout,
    input  logic              fifo_in_empty,
    output logic              fifo_out_wr_en,
    output logic [DWIDTH-1:0] fifo_out_din,
    input  logic              fifo_out_full,
    output logic              frame_done,
    output logic [15:0]       frame_count
);

    localparam int XW = CLOG2(IMG_WIDTH);
    localparam int YW = CLOG2(IMG_HEIGHT);

    // One extra bit so IMG_WIDTH-BORDER is representable when BORDER is 0.
    localparam logic [XW:0] X_LO = (XW + 1)'(BORDER);
    localparam logic [XW:0] X_HI = (XW + 1)'(IMG_WIDTH - BORDER);
    localparam logic [YW:0] Y_LO = (YW + 1)'(BORDER);
    localparam logic [YW:0] Y_HI = (YW + 1)'(IMG_HEIGHT - BORDER);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last_in_row;
    logic          last_in_frame;
    logic          is_edge;
    logic          drop;

    state_t            state_q, state_d;
    logic              out_valid_q, out_valid_d;
    logic [DWIDTH-1:0] dout_q, dout_d;
    logic              frame_done_q, frame_done_d;
    logic [15:0]       frame_count_q, frame_count_d;

    raster_counter #(
        .WIDTH  (IMG_WIDTH),
        .HEIGHT (IMG_HEIGHT)
    ) u_raster_counter (
        .clock         (clock),
        .reset         (reset),
        .advance       (fifo_in_rd_en),
        .x             (x),
        .y             (y),
        .last_in_row   (last_in_row),
        .last_in_frame (last_in_frame)
    );

    always_comb begin
        is_edge = ({1'b0, x} < X_LO) || ({1'b0, x} >= X_HI) ||
                  ({1'b0, y} < Y_LO) || ({1'b0, y} >= Y_HI);
        drop    = is_edge && (MODE == MODE_CROP);
    end

    always_comb begin
        state_d        = state_q;
        out_valid_d    = out_valid_q && fifo_out_full;
        dout_d         = dout_q;
        frame_done_d   = 1'b0;
        frame_count_d  = frame_count_q;
        fifo_in_rd_en  = 1'b0;
        fifo_out_wr_en = out_valid_q && !fifo_out_full && !reset;

        case (state_q)
            STREAM: begin
                // Dropped pixels never need the output slot, so they bypass backpressure.
                fifo_in_rd_en = !reset && !fifo_in_empty &&
                                (drop || !out_valid_q || !fifo_out_full);
                if (fifo_in_rd_en && last_in_row && last_in_frame) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!out_valid_q || fifo_out_wr_en) begin
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = STREAM;
                end
            end
            default: state_d = STREAM;
        endcase

        if (fifo_in_rd_en && !drop) begin
            out_valid_d = 1'b1;
            dout_d      = is_edge ? FILL_VALUE : fifo_in_dout;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= STREAM;
            out_valid_q   <= 1'b0;
            dout_q        <= '0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            out_valid_q   <= out_valid_d;
            dout_q        <= dout_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign fifo_out_din = dout_q;
    assign frame_done   = frame_done_q;
    assign frame_count  = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_op_depadder.sv
// ============================================================================
//  tb_op_depadder : FILL and CROP instances driven side by side against a model
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_op_depadder;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int B    = 1;
    localparam int NPIX = W * H;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rd_en  [2];
    logic       empty  [2];
    logic       wr_en  [2];
    logic       full   [2];
    logic       done   [2];
    logic [7:0] din_in [2];
    logic [7:0] dout   [2];
    logic [15:0] cnt   [2];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        op_depadder #(
            .DWIDTH     (8),
            .IMG_WIDTH  (W),
            .IMG_HEIGHT (H),
            .BORDER     (B),
            .MODE       (g),
            .FILL_VALUE (8'd0)
        ) u_dut (
            .clock          (clock),
            .reset          (reset),
            .fifo_in_rd_en  (rd_en[g]),
            .fifo_in_dout   (din_in[g]),
            .fifo_in_empty  (empty[g]),
            .fifo_out_wr_en (wr_en[g]),
            .fifo_out_din   (dout[g]),
            .fifo_out_full  (full[g]),
            .frame_done     (done[g]),
            .frame_count    (cnt[g])
        );
    end

    int checks = 0;
    int errors = 0;

    logic [7:0] srcq   [2][$];
    logic [7:0] expq   [2][$];
    logic [7:0] wr_log [2][$];
    int pos [2], nwr [2], npulse [2], pops [2], stall_pops [2];
    int first_pop [2], first_wr [2], last_wr [2];
    logic       prev_pop  [2];
    logic [7:0] prev_dout [2];
    bit  prev_rst = 1'b1;
    bit  rst_req  = 1'b1;
    bit  gap_alt  = 1'b0;
    int  gap_pct  = 0;
    int  stall_pct = 0;
    int  win_lo = 1000;
    int  win_hi = -1;
    int  cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int per_frame(input int d);
        return (d == 0) ? NPIX : (W - 2 * B) * (H - 2 * B);
    endfunction

    function automatic bit in_border(input int idx);
        int x, y;
        x = idx % W;
        y = idx / W;
        return (x < B) || (x >= W - B) || (y < B) || (y >= H - B);
    endfunction

    task automatic step();
        logic [7:0] v;
        bit         pop;
        @(negedge clock);
        reset = rst_req;
        for (int d = 0; d < 2; d++) begin
            empty[d]  = (srcq[d].size() == 0) || (gap_alt && (cyc % 2 == 1)) ||
                        ($urandom_range(99) < gap_pct);
            din_in[d] = empty[d] ? 8'($urandom) : srcq[d][0];
            full[d]   = (cyc >= win_lo && cyc <= win_hi) || ($urandom_range(99) < stall_pct);
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            check("pop_while_empty", 32'(rd_en[d] && empty[d]), 0);
            if (reset) begin
                check("rd_en_in_reset", 32'(rd_en[d]), 0);
                check("wr_en_in_reset", 32'(wr_en[d]), 0);
            end
            if (full[d]) check("wr_while_full", 32'(wr_en[d]), 0);
            if (!prev_pop[d] && !prev_rst) check("din_hold", 32'(dout[d]), 32'(prev_dout[d]));

            pop = rd_en[d] && !empty[d];
            if (pop) begin
                v = srcq[d].pop_front();
                if (d == 0) expq[d].push_back(in_border(pos[d]) ? 8'd0 : v);
                else if (!in_border(pos[d])) expq[d].push_back(v);
                pos[d] = (pos[d] + 1) % NPIX;
                if (pops[d] == 0) first_pop[d] = cyc;
                pops[d]++;
                if (full[d] && cyc >= win_lo && cyc <= win_hi) stall_pops[d]++;
            end
            if (wr_en[d]) begin
                check("spurious_write", 32'(expq[d].size() == 0), 0);
                if (expq[d].size() > 0) check("out_data", 32'(dout[d]), 32'(expq[d].pop_front()));
                wr_log[d].push_back(dout[d]);
                if (wr_log[d].size() == 1) first_wr[d] = cyc;
                last_wr[d] = cyc;
                nwr[d]++;
            end
            if (done[d]) begin
                npulse[d]++;
                check("count_at_done", 32'(cnt[d]), 32'(npulse[d]));
                check("writes_at_done", 32'(nwr[d]), 32'(npulse[d] * per_frame(d)));
            end
            prev_pop[d]  = pop;
            prev_dout[d] = dout[d];
        end
        prev_rst = reset;
        cyc++;
    endtask

    task automatic begin_phase();
        cyc = 0; win_lo = 1000; win_hi = -1; gap_pct = 0; stall_pct = 0; gap_alt = 1'b0;
        for (int d = 0; d < 2; d++) begin
            pops[d] = 0; stall_pops[d] = 0; wr_log[d].delete();
        end
    endtask

    task automatic load_frame(input bit rnd);
        logic [7:0] v;
        for (int i = 0; i < NPIX; i++) begin
            v = rnd ? 8'($urandom) : 8'((i / W) * 8 + (i % W) + 1);
            srcq[0].push_back(v);
            srcq[1].push_back(v);
        end
    endtask

    task automatic apply_reset(input int n);
        rst_req = 1'b1;
        repeat (n) step();
        rst_req = 1'b0;
        for (int d = 0; d < 2; d++) begin
            srcq[d].delete(); expq[d].delete();
            pos[d] = 0; nwr[d] = 0; npulse[d] = 0;
        end
    endtask

    task automatic run_frames(input int target, input int budget);
        int n = 0;
        while (n < budget && !(npulse[0] >= target && npulse[1] >= target)) begin
            step();
            n++;
        end
        repeat (2) step();
        for (int d = 0; d < 2; d++) begin
            check("frames_done", 32'(npulse[d]), 32'(target));
            check("frame_count", 32'(cnt[d]), 32'(target));
            check("expected_drained", 32'(expq[d].size()), 0);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            empty[d] = 1'b1; full[d] = 1'b0; din_in[d] = '0;
            pos[d] = 0; nwr[d] = 0; npulse[d] = 0; prev_pop[d] = 1'b0; prev_dout[d] = '0;
        end

        // Upstream holds data while reset is asserted: nothing may move.
        load_frame(1'b0);
        apply_reset(3);
        for (int d = 0; d < 2; d++) begin
            check("count_after_reset", 32'(cnt[d]), 0);
            check("done_after_reset", 32'(done[d]), 0);
        end

        // Free-flowing single frame with the y*8+x+1 pattern.
        begin_phase();
        load_frame(1'b0);
        run_frames(1, 300);
        check("fill_writes", 32'(wr_log[0].size()), 32'(NPIX));
        check("crop_writes", 32'(wr_log[1].size()), 32'((W - 2 * B) * (H - 2 * B)));
        if (wr_log[0].size() == NPIX) begin
            check("fill_corner", 32'(wr_log[0][0]), 0);
            check("fill_left_col", 32'(wr_log[0][8]), 0);
            check("fill_right_col", 32'(wr_log[0][15]), 0);
            check("fill_interior_3_2", 32'(wr_log[0][2 * W + 3]), 20);
            check("fill_last", 32'(wr_log[0][NPIX - 1]), 0);
        end
        if (wr_log[1].size() == (W - 2 * B) * (H - 2 * B)) begin
            check("crop_first", 32'(wr_log[1][0]), 32'(B * 8 + B + 1));
            check("crop_row2_first", 32'(wr_log[1][W - 2 * B]), 32'((B + 1) * 8 + B + 1));
            check("crop_last", 32'(wr_log[1][(W - 2 * B) * (H - 2 * B) - 1]),
                  32'((H - 1 - B) * 8 + (W - 1 - B) + 1));
        end
        check("fill_latency", 32'(first_wr[0] - first_pop[0]), 1);
        check("fill_no_bubbles", 32'(last_wr[0] - first_wr[0]), 32'(NPIX - 1));
        check("crop_first_latency", 32'(first_wr[1] - first_pop[1]), 32'(B * W + B + 1));

        // Downstream full for a fixed window mid-stream.
        begin_phase();
        load_frame(1'b0);
        win_lo = 5;
        win_hi = 14;
        run_frames(2, 400);
        check("fill_stall_pops_le1", 32'(stall_pops[0] <= 1), 1);
        check("fill_total_writes", 32'(nwr[0]), 32'(2 * NPIX));

        // Upstream empty every other cycle.
        begin_phase();
        gap_alt = 1'b1;
        load_frame(1'b0);
        run_frames(3, 600);

        // Random data, random gaps and stalls, three frames back to back.
        begin_phase();
        gap_pct   = 30;
        stall_pct = 30;
        repeat (3) load_frame(1'b1);
        run_frames(6, 3000);

        // Reset in the middle of a frame, then a fresh frame.
        begin_phase();
        load_frame(1'b1);
        for (int n = 0; n < 200 && !(pops[0] >= 20 && pops[1] >= 20); n++) step();
        check("pops_before_reset", 32'(pops[0] >= 20 && pops[1] >= 20), 1);
        apply_reset(2);
        for (int d = 0; d < 2; d++) check("count_after_midreset", 32'(cnt[d]), 0);
        begin_phase();
        load_frame(1'b0);
        run_frames(1, 300);
        check("fresh_fill_writes", 32'(nwr[0]), 32'(NPIX));
        check("fresh_crop_writes", 32'(nwr[1]), 32'((W - 2 * B) * (H - 2 * B)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
